// File: rtl/otter_hazard_ctrl.sv
// Hazard and forwarding controller for the pipelined OTTER core: a shadow scoreboard of
// EX..WB drives PC/IF-DE enables, flushes, bubbles, EX forward selects and perf counters.
module otter_hazard_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 32,
  localparam int FWD_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_valid,
  input  logic [ADDR_W-1:0] de_rs1,
  input  logic [ADDR_W-1:0] de_rs2,
  input  logic              de_rs1_used,
  input  logic              de_rs2_used,
  input  logic [ADDR_W-1:0] de_rd,
  input  logic              de_rd_used,
  input  logic              de_is_load,
  input  logic              br_taken,
  input  logic              mem_hold,
  output logic              pc_write,
  output logic              if_de_write,
  output logic              if_flush,
  output logic              de_ex_bubble,
  output logic              ex_valid,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              rd_used;
    logic              is_load;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
  } entry_t;

  // One action per cycle, in priority order hold > flush > stall > run.
  typedef enum logic [1:0] {
    ACT_RUN   = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2,
    ACT_HOLD  = 2'd3
  } action_e;

  entry_t  sb_q [DEPTH];
  entry_t  sb_d [DEPTH];
  entry_t  de_entry;
  action_e action;

  logic [DEPTH-1:0] de_hit1;
  logic [DEPTH-1:0] de_hit2;
  logic [DEPTH-1:0] load_early;
  logic [DEPTH-1:0] ex_hit1;
  logic [DEPTH-1:0] ex_hit2;
  logic             load_use;

  // The youngest matching producer decides; older matches are shadowed by it.
  function automatic logic youngest_is_early(input logic [DEPTH-1:0] hit,
                                             input logic [DEPTH-1:0] early);
    logic r;
    r = 1'b0;
    for (int p = DEPTH - 1; p >= 0; p--) begin
      if (hit[p]) r = early[p];
    end
    return r;
  endfunction

  function automatic logic [FWD_W-1:0] youngest_index(input logic [DEPTH-1:0] hit);
    logic [FWD_W-1:0] r;
    r = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (hit[k]) r = FWD_W'(k);
    end
    return r;
  endfunction

  always_comb begin
    de_entry.valid    = de_valid;
    de_entry.rd       = de_rd;
    de_entry.rd_used  = de_rd_used;
    de_entry.is_load  = de_is_load;
    de_entry.rs1      = de_rs1;
    de_entry.rs2      = de_rs2;
    de_entry.rs1_used = de_rs1_used;
    de_entry.rs2_used = de_rs2_used;
  end

  // Producer match vectors; x0 sources never match anything.
  always_comb begin
    de_hit1    = '0;
    de_hit2    = '0;
    load_early = '0;
    ex_hit1    = '0;
    ex_hit2    = '0;
    for (int p = 0; p < DEPTH; p++) begin
      if (sb_q[p].valid && sb_q[p].rd_used) begin
        de_hit1[p] = (sb_q[p].rd == de_rs1);
        de_hit2[p] = (sb_q[p].rd == de_rs2);
        ex_hit1[p] = (sb_q[p].rd == sb_q[0].rs1);
        ex_hit2[p] = (sb_q[p].rd == sb_q[0].rs2);
      end
      load_early[p] = sb_q[p].is_load && ((p + 1) < LOAD_STAGE);
    end
  end

  always_comb begin
    load_use = 1'b0;
    if (de_valid) begin
      if (de_rs1_used && (de_rs1 != '0) && youngest_is_early(de_hit1, load_early))
        load_use = 1'b1;
      if (de_rs2_used && (de_rs2 != '0) && youngest_is_early(de_hit2, load_early))
        load_use = 1'b1;
    end
  end

  always_comb begin
    if (mem_hold)      action = ACT_HOLD;
    else if (br_taken) action = ACT_FLUSH;
    else if (load_use) action = ACT_STALL;
    else               action = ACT_RUN;
  end

  always_comb begin
    pc_write     = 1'b1;
    if_de_write  = 1'b1;
    if_flush     = 1'b0;
    de_ex_bubble = 1'b0;
    case (action)
      ACT_HOLD: begin
        pc_write    = 1'b0;
        if_de_write = 1'b0;
      end
      ACT_FLUSH: begin
        if_flush     = 1'b1;
        de_ex_bubble = 1'b1;
      end
      ACT_STALL: begin
        pc_write     = 1'b0;
        if_de_write  = 1'b0;
        de_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ex_valid = sb_q[0].valid;
    fwd_a    = '0;
    fwd_b    = '0;
    if (sb_q[0].valid) begin
      if (sb_q[0].rs1_used && (sb_q[0].rs1 != '0)) fwd_a = youngest_index(ex_hit1);
      if (sb_q[0].rs2_used && (sb_q[0].rs2 != '0)) fwd_b = youngest_index(ex_hit2);
    end
  end

  // Entry DEPTH-1 simply falls off the end: its write has reached the register file.
  always_comb begin
    sb_d = sb_q;
    if (action != ACT_HOLD) begin
      for (int k = 1; k < DEPTH; k++) sb_d[k] = sb_q[k-1];
      sb_d[0] = (action == ACT_RUN) ? de_entry : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sb_q[k] <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (action == ACT_STALL && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (action == ACT_FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed bench for otter_hazard_ctrl: instance a uses default generics, instance b uses
// DEPTH=4, LOAD_STAGE=3, CNT_W=4. Both see the same stimulus.
module tb_otter_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       de_valid;
  logic [4:0] de_rs1;
  logic [4:0] de_rs2;
  logic       de_rs1_used;
  logic       de_rs2_used;
  logic [4:0] de_rd;
  logic       de_rd_used;
  logic       de_is_load;
  logic       br_taken;
  logic       mem_hold;

  logic        a_pc_write, a_if_de_write, a_if_flush, a_de_ex_bubble, a_ex_valid;
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_write, b_if_de_write, b_if_flush, b_de_ex_bubble, b_ex_valid;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  int errors = 0;
  int checks = 0;

  otter_hazard_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
    .de_rd_used(de_rd_used), .de_is_load(de_is_load), .br_taken(br_taken),
    .mem_hold(mem_hold), .pc_write(a_pc_write), .if_de_write(a_if_de_write),
    .if_flush(a_if_flush), .de_ex_bubble(a_de_ex_bubble), .ex_valid(a_ex_valid),
    .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  otter_hazard_ctrl #(.DEPTH(4), .LOAD_STAGE(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
    .de_rd_used(de_rd_used), .de_is_load(de_is_load), .br_taken(br_taken),
    .mem_hold(mem_hold), .pc_write(b_pc_write), .if_de_write(b_if_de_write),
    .if_flush(b_if_flush), .de_ex_bubble(b_de_ex_bubble), .ex_valid(b_ex_valid),
    .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic de_idle();
    de_valid = 1'b0; de_rs1 = '0; de_rs2 = '0; de_rs1_used = 1'b0; de_rs2_used = 1'b0;
    de_rd = '0; de_rd_used = 1'b0; de_is_load = 1'b0;
  endtask

  task automatic de_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic rd_used, input logic is_load);
    de_valid = 1'b1; de_rd = rd; de_rs1 = rs1; de_rs2 = rs2;
    de_rs1_used = 1'b1; de_rs2_used = 1'b1; de_rd_used = rd_used; de_is_load = is_load;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    de_idle();
    br_taken = 1'b0;
    mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_pc_write, a_if_de_write, a_if_flush, a_de_ex_bubble, a_ex_valid} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_ctrl_a got %b want 11000",
               {a_pc_write, a_if_de_write, a_if_flush, a_de_ex_bubble, a_ex_valid});
    end
    checks++;
    if ({a_fwd_a, a_fwd_b, a_stall_cnt, a_flush_cnt} !== 68'd0) begin
      errors++;
      $display("FAIL reset_fwd_cnt_a got fwd %0d/%0d cnt %0d/%0d want all 0",
               a_fwd_a, a_fwd_b, a_stall_cnt, a_flush_cnt);
    end
    checks++;
    if ({b_pc_write, b_if_de_write, b_if_flush, b_de_ex_bubble, b_ex_valid} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_ctrl_b got %b want 11000",
               {b_pc_write, b_if_de_write, b_if_flush, b_de_ex_bubble, b_ex_valid});
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    de_op(5'd5, 5'd1, 5'd2, 1'b1, 1'b0);
    tick();
    de_op(5'd6, 5'd5, 5'd3, 1'b1, 1'b0);
    #1;
    checks++;
    if ({a_pc_write, a_de_ex_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_no_stall got pc/bub %b want 10", {a_pc_write, a_de_ex_bubble});
    end
    tick();
    de_idle();
    #1;
    checks++;
    if ({a_ex_valid, a_fwd_a, a_fwd_b} !== 5'b1_01_00) begin
      errors++;
      $display("FAIL b2b_fwd1 got v=%b fa=%0d fb=%0d want v=1 fa=1 fb=0", a_ex_valid, a_fwd_a, a_fwd_b);
    end
    // Bubble between producer and consumer
    apply_reset();
    de_op(5'd5, 5'd1, 5'd2, 1'b1, 1'b0);
    tick();
    de_idle();
    tick();
    de_op(5'd6, 5'd5, 5'd3, 1'b1, 1'b0);
    tick();
    de_idle();
    #1;
    checks++;
    if (a_fwd_a !== 2'd2) begin
      errors++;
      $display("FAIL b2b_fwd2 got %0d want 2", a_fwd_a);
    end
    // Two producers of x5: the younger wins
    apply_reset();
    de_op(5'd5, 5'd1, 5'd2, 1'b1, 1'b0);
    tick();
    de_op(5'd5, 5'd1, 5'd1, 1'b1, 1'b0);
    tick();
    de_op(5'd8, 5'd5, 5'd5, 1'b1, 1'b0);
    tick();
    de_idle();
    #1;
    checks++;
    if ({a_fwd_a, a_fwd_b} !== 4'b01_01) begin
      errors++;
      $display("FAIL b2b_youngest got fa=%0d fb=%0d want 1/1", a_fwd_a, a_fwd_b);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    de_op(5'd6, 5'd1, 5'd0, 1'b1, 1'b1);
    tick();
    de_op(5'd7, 5'd6, 5'd6, 1'b1, 1'b0);
    #1;
    checks++;
    if ({a_pc_write, a_if_de_write, a_if_flush, a_de_ex_bubble} !== 4'b0001) begin
      errors++;
      $display("FAIL lu_stall got %b want 0001",
               {a_pc_write, a_if_de_write, a_if_flush, a_de_ex_bubble});
    end
    tick();
    checks++;
    if ({a_pc_write, a_de_ex_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL lu_release got pc/bub %b want 10", {a_pc_write, a_de_ex_bubble});
    end
    tick();
    de_idle();
    #1;
    checks++;
    if ({a_ex_valid, a_fwd_a, a_fwd_b} !== 5'b1_10_10 || a_stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL lu_fwd got v=%b fa=%0d fb=%0d stalls=%0d want 1 2 2 1",
               a_ex_valid, a_fwd_a, a_fwd_b, a_stall_cnt);
    end
  endtask

  task automatic test_load_stage3();
    apply_reset();
    de_op(5'd6, 5'd1, 5'd0, 1'b1, 1'b1);
    tick();
    de_op(5'd7, 5'd6, 5'd6, 1'b1, 1'b0);
    #1;
    checks++;
    if ({b_pc_write, b_de_ex_bubble} !== 2'b01) begin
      errors++;
      $display("FAIL ls3_stall1 got %b want 01", {b_pc_write, b_de_ex_bubble});
    end
    tick();
    checks++;
    if ({b_pc_write, b_de_ex_bubble} !== 2'b01) begin
      errors++;
      $display("FAIL ls3_stall2 got %b want 01", {b_pc_write, b_de_ex_bubble});
    end
    tick();
    checks++;
    if ({b_pc_write, b_de_ex_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL ls3_release got %b want 10", {b_pc_write, b_de_ex_bubble});
    end
    tick();
    de_idle();
    #1;
    checks++;
    if (b_fwd_a !== 2'd3 || b_stall_cnt !== 4'd2) begin
      errors++;
      $display("FAIL ls3_fwd got fa=%0d stalls=%0d want 3 2", b_fwd_a, b_stall_cnt);
    end
    // One independent instruction between load and consumer
    apply_reset();
    de_op(5'd6, 5'd1, 5'd0, 1'b1, 1'b1);
    tick();
    de_op(5'd9, 5'd1, 5'd2, 1'b1, 1'b0);
    #1;
    checks++;
    if (b_pc_write !== 1'b1) begin
      errors++;
      $display("FAIL ls3_indep got pc=%b want 1", b_pc_write);
    end
    tick();
    de_op(5'd7, 5'd6, 5'd6, 1'b1, 1'b0);
    #1;
    checks++;
    if ({b_pc_write, b_de_ex_bubble} !== 2'b01) begin
      errors++;
      $display("FAIL ls3_gap_stall got %b want 01", {b_pc_write, b_de_ex_bubble});
    end
    tick();
    checks++;
    if (b_pc_write !== 1'b1) begin
      errors++;
      $display("FAIL ls3_gap_release got pc=%b want 1", b_pc_write);
    end
    tick();
    de_idle();
    #1;
    checks++;
    if (b_fwd_a !== 2'd3 || b_stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL ls3_gap_fwd got fa=%0d stalls=%0d want 3 1", b_fwd_a, b_stall_cnt);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    de_op(5'd6, 5'd1, 5'd0, 1'b1, 1'b1);
    tick();
    de_op(5'd7, 5'd6, 5'd6, 1'b1, 1'b0);
    br_taken = 1'b1;
    #1;
    checks++;
    if ({a_pc_write, a_if_de_write, a_if_flush, a_de_ex_bubble} !== 4'b1111) begin
      errors++;
      $display("FAIL flush_ctrl got %b want 1111",
               {a_pc_write, a_if_de_write, a_if_flush, a_de_ex_bubble});
    end
    tick();
    br_taken = 1'b0;
    de_idle();
    #1;
    checks++;
    if (a_ex_valid !== 1'b0 || a_flush_cnt !== 32'd1 || a_stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL flush_after got v=%b flushes=%0d stalls=%0d want 0 1 0",
               a_ex_valid, a_flush_cnt, a_stall_cnt);
    end
  endtask

  task automatic test_mem_hold();
    apply_reset();
    de_op(5'd6, 5'd1, 5'd0, 1'b1, 1'b1);
    tick();
    de_op(5'd7, 5'd6, 5'd6, 1'b1, 1'b0);
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({a_pc_write, a_if_de_write, a_de_ex_bubble, a_ex_valid} !== 4'b0001 ||
          a_stall_cnt !== 32'd0) begin
        errors++;
        $display("FAIL hold_cycle%0d got pc/ifde/bub/v %b stalls=%0d want 0001 0", i,
                 {a_pc_write, a_if_de_write, a_de_ex_bubble, a_ex_valid}, a_stall_cnt);
      end
      tick();
    end
    mem_hold = 1'b0;
    #1;
    checks++;
    if ({a_pc_write, a_de_ex_bubble} !== 2'b01) begin
      errors++;
      $display("FAIL hold_then_stall got %b want 01", {a_pc_write, a_de_ex_bubble});
    end
    tick();
    tick();
    de_idle();
    #1;
    checks++;
    if (a_fwd_a !== 2'd2 || a_stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL hold_done got fa=%0d stalls=%0d want 2 1", a_fwd_a, a_stall_cnt);
    end
  endtask

  task automatic test_x0();
    apply_reset();
    de_op(5'd0, 5'd1, 5'd0, 1'b1, 1'b1);
    tick();
    de_op(5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
    #1;
    checks++;
    if ({a_pc_write, a_de_ex_bubble, b_pc_write, b_de_ex_bubble} !== 4'b1010) begin
      errors++;
      $display("FAIL x0_no_stall got %b want 1010",
               {a_pc_write, a_de_ex_bubble, b_pc_write, b_de_ex_bubble});
    end
    tick();
    de_idle();
    #1;
    checks++;
    if ({a_ex_valid, a_fwd_a, a_fwd_b} !== 5'b1_00_00) begin
      errors++;
      $display("FAIL x0_fwd got v=%b fa=%0d fb=%0d want 1 0 0", a_ex_valid, a_fwd_a, a_fwd_b);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    // Chain of loads each reading the previous load's destination
    de_op(5'd6, 5'd6, 5'd0, 1'b1, 1'b1);
    repeat (6) tick();
    checks++;
    if (b_stall_cnt !== 4'd4) begin
      errors++;
      $display("FAIL sat_early got %0d want 4", b_stall_cnt);
    end
    repeat (34) tick();
    de_idle();
    #1;
    checks++;
    if (a_stall_cnt !== 32'd20) begin
      errors++;
      $display("FAIL sat_a_count got %0d want 20", a_stall_cnt);
    end
    checks++;
    if (b_stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_b_clamp got %0d want 15", b_stall_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    de_op(5'd6, 5'd1, 5'd0, 1'b1, 1'b1);
    tick();
    de_op(5'd7, 5'd6, 5'd6, 1'b1, 1'b0);
    tick();
    checks++;
    if ({b_pc_write, b_de_ex_bubble} !== 2'b01 || b_stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL mid_pre got %b stalls=%0d want 01 1", {b_pc_write, b_de_ex_bubble}, b_stall_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b_pc_write, b_if_de_write, b_if_flush, b_de_ex_bubble, b_ex_valid} !== 5'b11000 ||
        b_stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset got %b stalls=%0d want 11000 0",
               {b_pc_write, b_if_de_write, b_if_flush, b_de_ex_bubble, b_ex_valid}, b_stall_cnt);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (b_pc_write !== 1'b1) begin
      errors++;
      $display("FAIL mid_release got pc=%b want 1", b_pc_write);
    end
    tick();
    de_idle();
    #1;
    checks++;
    if (b_ex_valid !== 1'b1 || b_stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL mid_after got v=%b stalls=%0d want 1 0", b_ex_valid, b_stall_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    br_taken = 1'b0;
    mem_hold = 1'b0;
    de_idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_load_stage3();
    test_flush();
    test_mem_hold();
    test_x0();
    test_saturate();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
